// File: rtl/ssg_scan_driver.sv
// rtl/ssg_scan_driver.sv - multiplexed common-anode seven-segment scan driver
// Scans one digit per slot with dead time, blink/blank, leading-zero suppression and frame-synchronous capture.
module ssg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      lz_en,
    output logic [7:0]                cathode,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [FR_W-1:0]         fcnt;
    logic                    blink_phase;
    logic                    capture_pending;

    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [NUM_DIGITS-1:0]   blink_sh;
    logic                    lz_sh;

    logic                    boundary;
    logic [NUM_DIGITS-1:0]   zero_up;
    logic                    run_zero;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    dark_sel;
    logic                    sup_sel;
    logic [7:0]              cathode_n;
    logic [NUM_DIGITS-1:0]   anode_n;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // zero_up[i] is set when nibble i and every more significant nibble are zero
    always_comb begin
        zero_up  = '0;
        run_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero && (digits_sh[4*i +: 4] == 4'h0);
            zero_up[i] = run_zero;
        end
    end

    always_comb begin
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        dark_sel = 1'b0;
        sup_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_sel  = digits_sh[4*i +: 4];
                dp_sel   = dp_sh[i];
                dark_sel = blank_sh[i] || (blink_sh[i] && blink_phase);
                sup_sel  = lz_sh && zero_up[i] && (i > 0);
            end
        end
    end

    always_comb begin
        cathode_n = 8'hFF;
        anode_n   = '1;
        if (!(cnt < DEAD_END) && !dark_sel) begin
            cathode_n = ~{dp_sel, (sup_sel ? 7'h00 : seg7(nib_sel))};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_n[i] = (idx != IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            idx             <= '0;
            fcnt            <= '0;
            blink_phase     <= 1'b0;
            capture_pending <= 1'b1;
            digits_sh       <= '0;
            dp_sh           <= '0;
            blank_sh        <= '0;
            blink_sh        <= '0;
            lz_sh           <= 1'b0;
            cathode         <= 8'hFF;
            anode           <= '1;
            frame_tick      <= 1'b0;
        end else begin
            cathode    <= cathode_n;
            anode      <= anode_n;
            frame_tick <= boundary;

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Shadow copy only changes between frames so a frame is never torn
            if (capture_pending || boundary) begin
                digits_sh       <= digits_in;
                dp_sh           <= dp_in;
                blank_sh        <= blank_in;
                blink_sh        <= blink_in;
                lz_sh           <= lz_en;
                capture_pending <= 1'b0;
            end

            if (boundary) begin
                if (fcnt == FR_LAST) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule
